// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants, FSM state encodings and the checksum
// helper for the instruction-memory boot loader.
// Optional feature macro: IMEM_LOADER_CKSUM_EN (trailing XOR checksum byte).
package imem_loader_pkg;

    // Default instruction memory geometry: 16384 words, 16-bit length header.
    localparam int ADDR_W_DEF = 14;
    localparam int LEN_W_DEF  = 16;

    // Loader FSM state encodings.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // Running checksum step: bytewise XOR accumulation.
    function automatic logic [7:0] cksum_next(input logic [7:0] acc,
                                              input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles four little-endian bytes into a 32-bit word.
// The first three bytes are parked in a lane register; the fourth byte is
// combined combinationally so the completed word is presented in the same
// cycle it is accepted, letting the parent register the write one cycle later.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] lanes;

    // Byte index counter and lane storage; clear discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            lanes <= 24'h00_0000;
        end else if (clear) begin
            idx   <= 2'd0;
            lanes <= 24'h00_0000;
        end else if (byte_valid) begin
            case (idx)
                2'd0:    lanes[7:0]   <= byte_in;
                2'd1:    lanes[15:8]  <= byte_in;
                2'd2:    lanes[23:16] <= byte_in;
                2'd3:    lanes        <= lanes;
                default: lanes        <= lanes;
            endcase
            idx <= idx + 2'd1;
        end else begin
            idx   <= idx;
            lanes <= lanes;
        end
    end

    // Completed word: the fourth byte lands in the top lane.
    always_comb begin
        word_valid = 1'b0;
        word       = {byte_in, lanes};
        if (byte_valid && !clear && (idx == 2'd3)) begin
            word_valid = 1'b1;
        end else begin
            word_valid = 1'b0;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction BRAM. Parses a byte
// stream of LEN_LO, LEN_HI, N*4 data bytes (and optionally one XOR checksum
// byte), packs little-endian words and writes them from word 0 upward.
// Optional feature macro: IMEM_LOADER_CKSUM_EN. When undefined there is no
// CSUM state and cksum_err is tied low.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              done,
    output logic              overflow,
    output logic              cksum_err
);

    // One extra bit so the word counter can reach N without wrapping.
    localparam int CW = LEN_W + 1;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t ST_END = ST_CSUM;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    state_t          state;
    logic [7:0]      len_lo;
    logic [LEN_W-1:0] len;
    logic [CW-1:0]   word_cnt;

    logic            accept;
    logic            data_accept;
    logic            pk_clear;
    logic            word_valid;
    logic [31:0]     word;
    logic            last_word;
    logic            addr_over;
    logic            len_zero;

    // Ready is a pure decode of the state so the source sees it immediately.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_LEN_LO: in_ready = 1'b1;
            ST_LEN_HI: in_ready = 1'b1;
            ST_DATA:   in_ready = 1'b1;
            ST_CSUM:   in_ready = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state == ST_DATA);
    // The packer only keeps a partial word while the payload is streaming.
    assign pk_clear    = (state != ST_DATA);
    assign last_word   = ((word_cnt + CW'(1)) == CW'(len));
    // Any word at or beyond the memory depth must not be written.
    assign addr_over   = ((word_cnt >> ADDR_W) != {CW{1'b0}});
    assign len_zero    = (LEN_W'({in_data, len_lo}) == {LEN_W{1'b0}});

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_valid (data_accept),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] cksum;
    logic       cksum_err_q;

    // Running XOR over payload bytes and the sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cksum       <= 8'h00;
            cksum_err_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            cksum       <= 8'h00;
            cksum_err_q <= 1'b0;
        end else if (data_accept) begin
            cksum       <= cksum_next(cksum, in_data);
            cksum_err_q <= cksum_err_q;
        end else if (accept && (state == ST_CSUM)) begin
            cksum       <= cksum;
            cksum_err_q <= (cksum != in_data);
        end else begin
            cksum       <= cksum;
            cksum_err_q <= cksum_err_q;
        end
    end

    assign cksum_err = cksum_err_q;
`else
    assign cksum_err = 1'b0;
`endif

    // Loader FSM, word counter, overflow flag and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_lo   <= 8'h00;
            len      <= {LEN_W{1'b0}};
            word_cnt <= {CW{1'b0}};
            we       <= 1'b0;
            waddr    <= {ADDR_W{1'b0}};
            wdata    <= 32'h0000_0000;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    word_cnt <= {CW{1'b0}};
                    state    <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len <= LEN_W'({in_data, len_lo});
                        if (len_zero) begin
                            state <= ST_END;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        if (addr_over) begin
                            overflow <= 1'b1;
                        end else begin
                            we    <= 1'b1;
                            waddr <= ADDR_W'(word_cnt);
                            wdata <= word;
                        end
                        word_cnt <= word_cnt + CW'(1);
                        if (last_word) begin
                            state <= ST_END;
                        end
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                ST_CSUM: begin
                    // Completion and checksum verdict publish together.
                    if (accept) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_W = 2 so overflow is reachable).
// Expected writes are queued by the stimulus; a negedge monitor pops them.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          done;
    logic          overflow;
    logic          cksum_err;

    int checks;
    int passes;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] exp_item;
    logic [7:0]     stim[$];

    imem_loader #(.ADDR_W(AW), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .done      (done),
        .overflow  (overflow),
        .cksum_err (cksum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_we: addr %0d data %08h with no write expected", waddr, wdata);
            end else begin
                exp_item = exp_q.pop_front();
                chk("waddr", 32'(waddr), 32'(exp_item[AW+31:32]));
                chk("wdata", wdata, exp_item[31:0]);
            end
        end
    end

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: in_ready %0b expected 1", in_ready);
        end
        @(posedge clk);
    endtask

    // Sends stim[], then checks completion timing and the sticky flags.
    task automatic run_stream(input string name, input int gap, input logic exp_cerr);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], gap);
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        chk({name, "_done_m1"}, 32'(done), 32'd1);
`else
        chk({name, "_done_t1"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({name, "_done_t2"}, 32'(done), 32'd1);
`endif
        chk({name, "_cksum_err"}, 32'(cksum_err), 32'(exp_cerr));
        repeat (2) @(negedge clk);
        chk({name, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_we"}, 32'(we), 32'd0);
        chk({name, "_waddr"}, 32'(waddr), 32'd0);
        chk({name, "_wdata"}, wdata, 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_overflow"}, 32'(overflow), 32'd0);
        chk({name, "_cksum_err"}, 32'(cksum_err), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        passes   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Basic two-word load.
        do_reset("rst0");
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h40, 8'h07};
`ifdef IMEM_LOADER_CKSUM_EN
        stim.push_back(8'hBB);
`endif
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0740_00EF);
        run_stream("two_word", 0, 1'b0);

        // After completion further bytes are refused and write nothing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h5A;
            chk("done_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_sticky", 32'(done), 32'd1);

        // Zero-length load.
        do_reset("rst1");
        stim = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
        stim.push_back(8'h00);
`endif
        run_stream("len_zero", 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        chk("len_zero_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // Same two-word load with a bubble before every byte.
        do_reset("rst2");
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h40, 8'h07};
`ifdef IMEM_LOADER_CKSUM_EN
        stim.push_back(8'hBB);
`endif
        expect_write(2'd0, 32'h0000_0013);
        expect_write(2'd1, 32'h0740_00EF);
        run_stream("gapped", 1, 1'b0);

        // Five words into a four-word memory: fifth word consumed, not written.
        do_reset("rst3");
        stim = '{8'h05, 8'h00,
                 8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                 8'h40, 8'h41, 8'h42, 8'h43};
`ifdef IMEM_LOADER_CKSUM_EN
        stim.push_back(8'h00);
`endif
        expect_write(2'd0, 32'h0302_0100);
        expect_write(2'd1, 32'h1312_1110);
        expect_write(2'd2, 32'h2322_2120);
        expect_write(2'd3, 32'h3332_3130);
        run_stream("overflow", 0, 1'b0);
        chk("overflow_flag", 32'(overflow), 32'd1);
        chk("overflow_done", 32'(done), 32'd1);

        // Abort after 1.5 words, then a fresh one-word load restarts at 0.
        do_reset("rst4");
        stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        expect_write(2'd0, 32'h4433_2211);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("partial_not_done", 32'(done), 32'd0);
        chk("partial_sb_drain", 32'(exp_q.size()), 32'd0);
        do_reset("rst_mid");
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CKSUM_EN
        stim.push_back(8'h00);
`endif
        expect_write(2'd0, 32'hDDCC_BBAA);
        run_stream("restart", 0, 1'b0);

`ifdef IMEM_LOADER_CKSUM_EN
        // Checksum good and bad cases.
        do_reset("rst5");
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        expect_write(2'd0, 32'h0000_0013);
        run_stream("cksum_ok", 0, 1'b0);
        do_reset("rst6");
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        expect_write(2'd0, 32'h0000_0013);
        run_stream("cksum_bad", 0, 1'b1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
